eth_tx_framer: RTL and testbench

- Sits between the frame byte-mux (Ethernet/IP/UDP header and payload generators) and the RGMII DDR output stage.
- Takes one frame at a time as a byte stream with valid/last/ready handshake.
- Emits a continuous GMII-style byte stream: 7x preamble, SFD, payload, zero padding to the minimum length, 4-byte CRC32 FCS, then enforces the inter-frame gap.
- Owns the frame-level CRC, so upstream generators never see or compute the FCS.

---
 rtl/eth_pkg.sv | 29 ++
 rtl/eth_crc32_byte.sv | 20 ++
 rtl/eth_tx_framer.sv | 170 +++++++++++++++++
 tb/tb_eth_tx_framer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet transmit path: framing constants,
// CRC32 parameters and the framer state encoding.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam int          ETH_PRE_LEN     = 7;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_PAYLOAD,
        ST_PAD,
        ST_FCS,
        ST_DRAIN,
        ST_IFG
    } tx_state_t;

    // FCS byte idx (0 = least significant) of the complemented running CRC.
    function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
        logic [31:0] w_inv;
        w_inv = ~crc;
        return w_inv[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational one-byte step of the reflected IEEE 802.3 CRC32 (LSB first).
// Shared by the transmit framer and the receive checker.
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    always_comb begin
        logic [31:0] w_crc;
        w_crc = i_crc ^ {24'd0, i_data};
        for (int i = 0; i < 8; i++) begin
            w_crc = w_crc[0] ? ((w_crc >> 1) ^ CRC32_POLY_REFL) : (w_crc >> 1);
        end
        o_crc = w_crc;
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: wraps an upstream byte stream with preamble/SFD,
// pads to the minimum length, appends the FCS and enforces the inter-frame gap.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int MIN_FRAME  = 60,
    parameter int MAX_FRAME  = 1514,
    parameter int IFG_CYCLES = 12,
    parameter bit PAD_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_err,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [15:0] abort_cnt
);

    localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_LEN  = 11'(MAX_FRAME);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);
    // IDLE already emits the first preamble byte, so PRE covers the rest.
    localparam logic [7:0]  PRE_LAST = 8'(ETH_PRE_LEN - 2);

    tx_state_t   r_state,     w_state_nxt;
    logic [7:0]  r_m_data,    w_m_data_nxt;
    logic        r_m_valid,   w_m_valid_nxt;
    logic        r_m_err,     w_m_err_nxt;
    logic [31:0] r_crc,       w_crc_nxt;
    logic [10:0] r_count,     w_count_nxt;
    logic [7:0]  r_timer,     w_timer_nxt;
    logic [15:0] r_frame_cnt, w_frame_cnt_nxt;
    logic [15:0] r_abort_cnt, w_abort_cnt_nxt;

    logic [7:0]  w_crc_din;
    logic [31:0] w_crc_step;

    assign w_crc_din = (r_state == ST_PAD) ? 8'h00 : s_data;

    eth_crc32_byte u_crc (
        .i_crc  (r_crc),
        .i_data (w_crc_din),
        .o_crc  (w_crc_step)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_state_nxt     = r_state;
        w_m_data_nxt    = 8'h00;
        w_m_valid_nxt   = 1'b0;
        w_m_err_nxt     = 1'b0;
        w_crc_nxt       = r_crc;
        w_count_nxt     = r_count;
        w_timer_nxt     = r_timer;
        w_frame_cnt_nxt = r_frame_cnt;
        w_abort_cnt_nxt = r_abort_cnt;

        case (r_state)
            ST_IDLE: begin
                if (s_valid) begin
                    w_state_nxt   = ST_PRE;
                    w_m_data_nxt  = ETH_PREAMBLE;
                    w_m_valid_nxt = 1'b1;
                    w_timer_nxt   = 8'd0;
                end
            end
            ST_PRE: begin
                w_m_data_nxt  = ETH_PREAMBLE;
                w_m_valid_nxt = 1'b1;
                w_timer_nxt   = r_timer + 8'd1;
                if (r_timer == PRE_LAST) w_state_nxt = ST_SFD;
            end
            ST_SFD: begin
                w_m_data_nxt  = ETH_SFD;
                w_m_valid_nxt = 1'b1;
                w_crc_nxt     = CRC32_INIT;
                w_count_nxt   = 11'd0;
                w_state_nxt   = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                w_m_valid_nxt = 1'b1;
                if (r_count == MAX_LEN || !s_valid) begin
                    // Underrun or oversize: flag TX_ER and discard the remainder.
                    w_m_err_nxt     = 1'b1;
                    w_abort_cnt_nxt = r_abort_cnt + 16'd1;
                    w_timer_nxt     = 8'd0;
                    w_state_nxt     = (s_valid && s_last) ? ST_IFG : ST_DRAIN;
                end else begin
                    w_m_data_nxt = s_data;
                    w_crc_nxt    = w_crc_step;
                    w_count_nxt  = r_count + 11'd1;
                    if (s_last) begin
                        w_timer_nxt = 8'd0;
                        w_state_nxt = (PAD_EN && (r_count + 11'd1 < MIN_LEN)) ? ST_PAD : ST_FCS;
                    end
                end
            end
            ST_PAD: begin
                w_m_valid_nxt = 1'b1;
                w_crc_nxt     = w_crc_step;
                w_count_nxt   = r_count + 11'd1;
                if (r_count + 11'd1 == MIN_LEN) begin
                    w_timer_nxt = 8'd0;
                    w_state_nxt = ST_FCS;
                end
            end
            ST_FCS: begin
                w_m_data_nxt  = fcs_byte(r_crc, r_timer[1:0]);
                w_m_valid_nxt = 1'b1;
                w_timer_nxt   = r_timer + 8'd1;
                if (r_timer == 8'd3) begin
                    w_frame_cnt_nxt = r_frame_cnt + 16'd1;
                    w_timer_nxt     = 8'd0;
                    w_state_nxt     = ST_IFG;
                end
            end
            ST_DRAIN: begin
                if (s_valid && s_last) begin
                    w_timer_nxt = 8'd0;
                    w_state_nxt = ST_IFG;
                end
            end
            ST_IFG: begin
                w_timer_nxt = r_timer + 8'd1;
                if (r_timer == IFG_LAST) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_m_data    <= 8'h00;
            r_m_valid   <= 1'b0;
            r_m_err     <= 1'b0;
            r_crc       <= CRC32_INIT;
            r_count     <= 11'd0;
            r_timer     <= 8'd0;
            r_frame_cnt <= 16'd0;
            r_abort_cnt <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_m_data    <= w_m_data_nxt;
            r_m_valid   <= w_m_valid_nxt;
            r_m_err     <= w_m_err_nxt;
            r_crc       <= w_crc_nxt;
            r_count     <= w_count_nxt;
            r_timer     <= w_timer_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_abort_cnt <= w_abort_cnt_nxt;
        end
    end

    assign s_ready   = (r_state == ST_PAYLOAD) || (r_state == ST_DRAIN);
    assign busy      = (r_state != ST_IDLE);
    assign m_data    = r_m_data;
    assign m_valid   = r_m_valid;
    assign m_err     = r_m_err;
    assign frame_cnt = r_frame_cnt;
    assign abort_cnt = r_abort_cnt;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: one padded and one unpadded instance,
// expected wire bytes queued by the stimulus and popped by a negedge monitor.
module tb_eth_tx_framer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        use_np;

    logic        d_ready, d_mvalid, d_merr, d_busy;
    logic [7:0]  d_mdata;
    logic [15:0] d_fcnt, d_acnt;
    logic        n_ready, n_mvalid, n_merr, n_busy;
    logic [7:0]  n_mdata;
    logic [15:0] n_fcnt, n_acnt;

    logic        w_ready, w_mvalid, w_merr, w_busy;
    logic [7:0]  w_mdata;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [8:0]  exp_q[$];
    logic [7:0]  tx_buf[2048];
    int          cyc = 0;
    int          last_cyc = 0;
    int          start_delay = 0;
    bit          prev_mv = 1'b0;

    initial clk = 1'b0;
    always #4 clk = ~clk;

    eth_tx_framer #(.PAD_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid && !use_np),
        .s_last(s_last), .s_ready(d_ready), .m_data(d_mdata), .m_valid(d_mvalid),
        .m_err(d_merr), .busy(d_busy), .frame_cnt(d_fcnt), .abort_cnt(d_acnt)
    );

    eth_tx_framer #(.PAD_EN(1'b0)) u_np (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid && use_np),
        .s_last(s_last), .s_ready(n_ready), .m_data(n_mdata), .m_valid(n_mvalid),
        .m_err(n_merr), .busy(n_busy), .frame_cnt(n_fcnt), .abort_cnt(n_acnt)
    );

    assign w_ready  = use_np ? n_ready  : d_ready;
    assign w_mvalid = use_np ? n_mvalid : d_mvalid;
    assign w_merr   = use_np ? n_merr   : d_merr;
    assign w_mdata  = use_np ? n_mdata  : d_mdata;
    assign w_busy   = use_np ? n_busy   : d_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bit-serial reference CRC over tx_buf[0..n-1] followed by zero padding up to len.
    function automatic logic [31:0] ref_fcs(input int n, input int len);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            b = (i < n) ? tx_buf[i] : 8'h00;
            for (int k = 0; k < 8; k++) begin
                if (c[0] ^ b[k]) c = (c >> 1) ^ 32'hEDB88320;
                else             c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic push_head();
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
    endtask

    task automatic push_bytes(input int n, input int len);
        for (int i = 0; i < len; i++) exp_q.push_back({1'b0, (i < n) ? tx_buf[i] : 8'h00});
    endtask

    task automatic push_fcs(input logic [31:0] fcs);
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, fcs[8*k +: 8]});
    endtask

    task automatic push_frame(input int n, input bit pad);
        int len;
        len = (pad && n < 60) ? 60 : n;
        push_head();
        push_bytes(n, len);
        push_fcs(ref_fcs(n, len));
    endtask

    task automatic push_abort(input int n);
        push_head();
        push_bytes(n, n);
        exp_q.push_back({1'b1, 8'h00});
    endtask

    // Drive n bytes from tx_buf; optional one-cycle valid hole before byte `hole`,
    // optional reset asserted together with the final valid drop.
    task automatic drive(input int n, input bit with_last, input int hole, input bit rst_at_end);
        int  i;
        int  stall;
        bit  holed;
        bit  acc;
        i = 0; stall = 0; holed = 1'b0;
        while (i < n) begin
            if (i == hole && !holed) begin
                holed   = 1'b1;
                s_valid = 1'b0;
                s_last  = 1'b0;
                @(posedge clk); #1;
            end else begin
                s_valid = 1'b1;
                s_data  = tx_buf[i];
                s_last  = with_last && (i == n - 1);
                @(negedge clk);
                acc = w_ready;
                @(posedge clk); #1;
                if (acc) begin
                    i++;
                    stall = 0;
                end else if (++stall > 100) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL drive_stall: byte %0d not accepted within 100 cycles", i);
                    i = n;
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (rst_at_end) rst_n = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (w_busy && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check({name, "_idle"}, w_busy, 0);
        check({name, "_q_empty"}, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (w_mvalid || w_merr) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL m_unexpected: got err=%0b data=%02h expected no output", w_merr, w_mdata);
            end else begin
                check("m_byte", {w_merr, w_mdata}, exp_q.pop_front());
            end
            if (!prev_mv) start_delay = cyc - last_cyc;
            last_cyc = cyc;
        end
        prev_mv = w_mvalid;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: run exceeded 1 ms, required to finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; use_np = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", d_mvalid, 0);
        check("rst_m_data", d_mdata, 0);
        check("rst_m_err", d_merr, 0);
        check("rst_s_ready", d_ready, 0);
        check("rst_busy", d_busy, 0);
        check("rst_frame_cnt", d_fcnt, 0);
        check("rst_abort_cnt", d_acnt, 0);
        check("rst_np_busy", n_busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Unpadded "123456789" with its well-known FCS, then "ABC" held off during IFG.
        use_np = 1'b1;
        for (int i = 0; i < 9; i++) tx_buf[i] = 8'(8'h31 + i);
        push_head();
        push_bytes(9, 9);
        push_fcs(32'hCBF43926);
        drive(9, 1'b1, -1, 1'b0);
        tx_buf[0] = 8'h41; tx_buf[1] = 8'h42; tx_buf[2] = 8'h43;
        push_frame(3, 1'b0);
        drive(3, 1'b1, -1, 1'b0);
        wait_idle("nopad");
        check("nopad_b2b_start", start_delay, 13);
        check("nopad_frame_cnt", n_fcnt, 2);
        check("nopad_abort_cnt", n_acnt, 0);
        use_np = 1'b0;

        // 42-byte frame padded to 60.
        for (int i = 0; i < 42; i++) tx_buf[i] = 8'(i * 13 + 7);
        push_frame(42, 1'b1);
        drive(42, 1'b1, -1, 1'b0);
        wait_idle("pad42");
        check("pad42_frame_cnt", d_fcnt, 1);

        // Underrun after 20 payload bytes.
        for (int i = 0; i < 30; i++) tx_buf[i] = 8'(8'hA0 + i);
        push_abort(20);
        drive(30, 1'b1, 20, 1'b0);
        wait_idle("underrun");
        check("underrun_abort_cnt", d_acnt, 1);
        check("underrun_frame_cnt", d_fcnt, 1);

        // Oversize: 1600 bytes, abort after byte 1514.
        for (int i = 0; i < 1600; i++) tx_buf[i] = 8'(i ^ (i >> 8));
        push_abort(1514);
        drive(1600, 1'b1, -1, 1'b0);
        wait_idle("oversize");
        check("oversize_abort_cnt", d_acnt, 2);
        check("oversize_frame_cnt", d_fcnt, 1);

        // Back-to-back: exactly MIN_FRAME (no pad) then MIN_FRAME-1 (one pad byte).
        for (int i = 0; i < 60; i++) tx_buf[i] = 8'(i * 3 + 1);
        push_frame(60, 1'b1);
        drive(60, 1'b1, -1, 1'b0);
        for (int i = 0; i < 59; i++) tx_buf[i] = 8'(8'hF0 - i);
        push_frame(59, 1'b1);
        drive(59, 1'b1, -1, 1'b0);
        wait_idle("b2b");
        check("b2b_start", start_delay, 13);
        check("b2b_frame_cnt", d_fcnt, 3);

        // Reset during PAYLOAD truncates at once; next frame is clean.
        for (int i = 0; i < 10; i++) tx_buf[i] = 8'(8'h10 + i);
        push_head();
        push_bytes(10, 10);
        drive(10, 1'b0, -1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("midrst_m_valid", d_mvalid, 0);
        check("midrst_s_ready", d_ready, 0);
        check("midrst_busy", d_busy, 0);
        check("midrst_frame_cnt", d_fcnt, 0);
        check("midrst_q_empty", exp_q.size(), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) tx_buf[i] = 8'(8'h31 + i);
        push_frame(9, 1'b1);
        drive(9, 1'b1, -1, 1'b0);
        wait_idle("postrst");
        check("postrst_frame_cnt", d_fcnt, 1);
        check("postrst_abort_cnt", d_acnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
